// File: rtl/key_matrix_scanner.sv
// 4x4 key matrix scanner: active-low row drive, 2-FF column sync, press/release debounce.
// Optional auto-repeat while a key stays held: define KEY_REPEAT_EN.
module key_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_RATE    = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEY,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 2 || DEBOUNCE_SCANS > 15 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_matrix_scanner: parameter out of legal range");
    end

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_col_s1, r_csync;
    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_row_ptr, w_row_ptr_nxt;
    logic [3:0]         r_code, w_code_nxt;
    // Press streak while debouncing, release streak while held.
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]         r_key, w_key_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_held, w_held_nxt;
    logic               w_tick, w_any_low, w_cap_low, w_cnt_done, w_rel_done;
    logic [1:0]         w_col_idx;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nxt, w_rep_inc, w_rep_target;
    logic             r_rep_first, w_rep_first_nxt;

    assign w_rep_inc    = r_rep_cnt + REP_W'(1);
    assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_RATE);
`endif

    assign w_tick     = (r_presc == PRESC_W'(SCAN_DIV - 1));
    assign w_any_low  = ~&r_csync;
    assign w_cap_low  = ~r_csync[r_code[1:0]];
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_cnt_done = (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS));
    assign w_rel_done = ~w_cap_low & w_cnt_done;

    assign ROW       = ~(4'b0001 << r_row_ptr);
    assign KEY       = r_key;
    assign KEY_VALID = r_valid;
    assign KEY_HELD  = r_held;

    // Lowest-index low column wins when several are pressed in one row.
    always_comb begin
        w_col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_csync[i]) w_col_idx = 2'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_presc  <= '0;
            r_col_s1 <= 4'hF;
            r_csync  <= 4'hF;
        end else begin
            r_col_s1 <= COL;
            r_csync  <= r_col_s1;
            r_presc  <= w_tick ? '0 : r_presc + PRESC_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= SCAN;
            r_row_ptr   <= 2'd0;
            r_code      <= 4'd0;
            r_cnt       <= '0;
            r_key       <= 4'd0;
            r_valid     <= 1'b0;
            r_held      <= 1'b0;
`ifdef KEY_REPEAT_EN
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_row_ptr   <= w_row_ptr_nxt;
            r_code      <= w_code_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key       <= w_key_nxt;
            r_valid     <= w_valid_nxt;
            r_held      <= w_held_nxt;
`ifdef KEY_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_first <= w_rep_first_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_ptr_nxt = r_row_ptr;
        w_code_nxt    = r_code;
        w_cnt_nxt     = r_cnt;
        w_key_nxt     = r_key;
        w_valid_nxt   = 1'b0;
        w_held_nxt    = r_held;
`ifdef KEY_REPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_first_nxt = r_rep_first;
`endif
        if (w_tick) begin
            case (r_state)
                SCAN: begin
                    if (w_any_low) begin
                        w_code_nxt  = {r_row_ptr, w_col_idx};
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = DEBOUNCE;
                    end else begin
                        w_row_ptr_nxt = r_row_ptr + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (w_any_low && (w_col_idx == r_code[1:0])) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_done) begin
                            w_key_nxt   = r_code;
                            w_valid_nxt = 1'b1;
                            w_held_nxt  = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = HELD;
`ifdef KEY_REPEAT_EN
                            w_rep_cnt_nxt   = '0;
                            w_rep_first_nxt = 1'b1;
`endif
                        end
                    end else begin
                        w_cnt_nxt     = '0;
                        w_row_ptr_nxt = r_row_ptr + 2'd1;
                        w_state_nxt   = SCAN;
                    end
                end
                HELD: begin
                    if (w_cap_low) begin
                        w_cnt_nxt = '0;
                    end else if (w_cnt_done) begin
                        w_cnt_nxt     = '0;
                        w_held_nxt    = 1'b0;
                        w_row_ptr_nxt = r_row_ptr + 2'd1;
                        w_state_nxt   = SCAN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
`ifdef KEY_REPEAT_EN
                    // Repeat timing keeps running through a partial release.
                    if (!w_rel_done) begin
                        if (w_rep_inc == w_rep_target) begin
                            w_valid_nxt     = 1'b1;
                            w_rep_cnt_nxt   = '0;
                            w_rep_first_nxt = 1'b0;
                        end else begin
                            w_rep_cnt_nxt = w_rep_inc;
                        end
                    end
`endif
                end
                default: w_state_nxt = SCAN;
            endcase
        end
    end

`ifndef KEY_REPEAT_EN
    logic w_unused;
    assign w_unused = w_rel_done;
`endif

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Scoreboard bench for key_matrix_scanner: a virtual key matrix drives COL from ROW,
// a tick-level reference model predicts strobes, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_key_matrix_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int RDELAY   = 5;
    localparam int RRATE    = 2;

    localparam int M_SCAN = 0;
    localparam int M_PEND = 1;
    localparam int M_HELD = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] COL;
    logic [3:0] ROW;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       KEY_HELD;

    bit pressed [16];

    typedef struct {
        int key;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int since_rst = 0;
    bit tick_seen;

    int m_row, m_mode, m_code, m_streak, m_rel, m_key, m_held, m_age;

    key_matrix_scanner #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_DELAY(RDELAY),
        .REPEAT_RATE(RRATE)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .COL(COL),
        .ROW(ROW),
        .KEY(KEY),
        .KEY_VALID(KEY_VALID),
        .KEY_HELD(KEY_HELD)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Physical matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        COL = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!ROW[r] && pressed[r*4+c]) COL[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] row_pattern(input int r);
        logic [3:0] p;
        p = 4'hF;
        p[r] = 1'b0;
        return p;
    endfunction

    function automatic int first_col(input int r);
        for (int c = 0; c < 4; c++)
            if (pressed[r*4+c]) return c;
        return -1;
    endfunction

    task automatic expect_strobe(input int k);
        exp_t e;
        e.key = k;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_row = 0; m_mode = M_SCAN; m_code = 0; m_streak = 0;
        m_rel = 0; m_key = 0; m_held = 0; m_age = 0;
    endtask

    task automatic model_tick();
        int c;
        c = first_col(m_row);
        case (m_mode)
            M_SCAN: begin
                if (c < 0) m_row = (m_row + 1) % 4;
                else begin
                    m_code = m_row * 4 + c;
                    m_streak = 1;
                    m_mode = M_PEND;
                end
            end
            M_PEND: begin
                if (c >= 0 && m_row * 4 + c == m_code) begin
                    m_streak++;
                    if (m_streak == DEB) begin
                        m_key = m_code; m_held = 1; m_mode = M_HELD; m_rel = 0; m_age = 0;
                        expect_strobe(m_key);
                    end
                end else begin
                    m_mode = M_SCAN;
                    m_row = (m_row + 1) % 4;
                end
            end
            default: begin
                if (pressed[m_code]) m_rel = 0;
                else m_rel++;
                if (m_rel == DEB) begin
                    m_held = 0; m_mode = M_SCAN; m_row = (m_row + 1) % 4;
                end
`ifdef KEY_REPEAT_EN
                else begin
                    m_age++;
                    if (m_age == RDELAY || (m_age > RDELAY && (m_age - RDELAY) % RRATE == 0))
                        expect_strobe(m_key);
                end
`endif
            end
        endcase
    endtask

    task automatic cycle();
        @(negedge CLK);
        if (RESET) begin
            since_rst = 0;
            model_reset();
            chk("reset_ROW", ROW, 4'b1110);
            chk("reset_KEY", KEY, 0);
            chk("reset_KEY_HELD", KEY_HELD, 0);
            chk("reset_KEY_VALID", KEY_VALID, 0);
        end else begin
            since_rst++;
            if (since_rst % SCAN_DIV == 0) begin
                model_tick();
                tick_seen = 1'b1;
            end
            chk("ROW", ROW, row_pattern(m_row));
            chk("KEY", KEY, m_key);
            chk("KEY_HELD", KEY_HELD, m_held);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_seen = 1'b0;
            while (!tick_seen) cycle();
        end
    endtask

    task automatic wait_mode(input int mode, input int max_ticks);
        for (int i = 0; i < max_ticks; i++) begin
            if (m_mode == mode) break;
            run_ticks(1);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
    endtask

    task automatic release_all();
        foreach (pressed[i]) pressed[i] = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (KEY_VALID !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: KEY_VALID=%b KEY=%0d, required no strobe (cycle %0d)",
                             KEY_VALID, KEY, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_KEY", KEY, e.key);
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int k;
        release_all();
        RESET = 1'b1;
        cycle();
        cycle();
        RESET = 1'b0;

        // Idle scan with no keys.
        run_ticks(16);

        // Key 9 held, then released.
        pressed[9] = 1'b1;
        run_ticks(10);
        pressed[9] = 1'b0;
        run_ticks(8);

        // Key 9 bounces away on the second sample.
        pressed[9] = 1'b1;
        wait_mode(M_PEND, 8);
        pressed[9] = 1'b0;
        run_ticks(6);

        // Two columns in row 0 together, then key 15 during HELD.
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        wait_mode(M_HELD, 12);
        pressed[15] = 1'b1;
        run_ticks(6);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        run_ticks(10);
        pressed[15] = 1'b0;
        run_ticks(8);

        // Reset while a key is being debounced.
        pressed[6] = 1'b1;
        wait_mode(M_PEND, 8);
        do_reset();
        pressed[6] = 1'b0;
        run_ticks(6);

        // Long hold of key 9.
        pressed[9] = 1'b1;
        run_ticks(24);
        pressed[9] = 1'b0;
        run_ticks(8);

        // Random key activity with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                k = $urandom_range(0, 15);
                pressed[k] = !pressed[k];
            end else if (r < 18) begin
                release_all();
            end else if (r == 18) begin
                do_reset();
            end
            run_ticks(1);
        end

        release_all();
        run_ticks(10);
        repeat (3) cycle();
        chk("outstanding_strobes", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
